cla_addsub_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor: the next generation of our 4-bit PFA/CarryLookaheadLogic adder, generalised to WIDTH bits as a two-level lookahead over 4-bit groups. It adds an add/sub mode and valid/ready flow control on both sides. It sits in the datapath wherever a registered wide add is needed, for example ALU back-ends and accumulators, and sustains one operation per cycle.

---
 rtl/cla_addsub_pipe.sv | 164 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined WIDTH-bit carry-lookahead adder/subtractor with valid/ready.
// Define CLA_PIPE_FLAGS_EN to build the registered signed-overflow and zero flags.
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_p,
    output logic             out_g,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int GROUPS = WIDTH / 4;

    logic              s1_v_q, s2_v_q, s1_adv, s2_adv, s1_ld, s2_ld;
    logic [WIDTH-1:0]  b_x, p_d, g_d, p_q, g_q, sum_d, sum_q;
    logic [GROUPS-1:0] gp_d, gg_d, gp_q, gg_q;
    logic              c0_d, c0_q;
    logic [GROUPS:0]   gc;
    logic [WIDTH:0]    c;
    logic              blk_g_d, blk_p_d, cout_q, blk_p_q, blk_g_q;

    assign s2_adv   = ~s2_v_q | out_ready;
    assign s1_adv   = ~s1_v_q | s2_adv;
    assign in_ready = s1_adv;
    assign s1_ld    = s1_adv & in_valid;
    assign s2_ld    = s2_adv & s1_v_q;

    assign b_x  = in_sub ? ~in_b : in_b;
    assign c0_d = in_sub ? ~in_cin : in_cin;
    assign p_d  = in_a ^ b_x;
    assign g_d  = in_a & b_x;

    always_comb begin
        gp_d = '0;
        gg_d = '0;
        for (int k = 0; k < GROUPS; k++) begin
            gp_d[k] = &p_d[4*k +: 4];
            gg_d[k] = g_d[4*k+3] | (p_d[4*k+3] & g_d[4*k+2]) | (&p_d[4*k+2 +: 2] & g_d[4*k+1])
                    | (&p_d[4*k+1 +: 3] & g_d[4*k]);
        end
    end

    // Each group carry is its own sum of products over all lower groups, so nothing ripples.
    always_comb begin
        logic pr;
        pr      = 1'b1;
        gc      = '0;
        blk_g_d = 1'b0;
        for (int k = 0; k <= GROUPS; k++) begin
            pr = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                gc[k] = gc[k] | (pr & gg_q[j]);
                pr    = pr & gp_q[j];
            end
            if (k == GROUPS) blk_g_d = gc[k];
            gc[k] = gc[k] | (pr & c0_q);
        end
    end

    always_comb begin
        logic pr;
        pr = 1'b1;
        c  = '0;
        for (int k = 0; k < GROUPS; k++) begin
            for (int i = 0; i < 4; i++) begin
                pr = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    c[4*k+i] = c[4*k+i] | (pr & g_q[4*k+j]);
                    pr       = pr & p_q[4*k+j];
                end
                c[4*k+i] = c[4*k+i] | (pr & gc[k]);
            end
        end
        c[WIDTH] = gc[GROUPS];
    end

    assign sum_d   = p_q ^ c[WIDTH-1:0];
    assign blk_p_d = &gp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            p_q    <= '0;
            g_q    <= '0;
            gp_q   <= '0;
            gg_q   <= '0;
            c0_q   <= 1'b0;
        end else begin
            if (s1_adv) s1_v_q <= in_valid;
            if (s1_ld) begin
                p_q  <= p_d;
                g_q  <= g_d;
                gp_q <= gp_d;
                gg_q <= gg_d;
                c0_q <= c0_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            blk_p_q <= 1'b0;
            blk_g_q <= 1'b0;
        end else begin
            if (s2_adv) s2_v_q <= s1_v_q;
            if (s2_ld) begin
                sum_q   <= sum_d;
                cout_q  <= c[WIDTH];
                blk_p_q <= blk_p_d;
                blk_g_q <= blk_g_d;
            end
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    logic am_q, bm_q, ovf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am_q <= 1'b0;
            bm_q <= 1'b0;
        end else if (s1_ld) begin
            am_q <= in_a[WIDTH-1];
            bm_q <= b_x[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (s2_ld) begin
            ovf_q  <= (am_q == bm_q) & (sum_d[WIDTH-1] != am_q);
            zero_q <= ~|sum_d;
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif

    assign out_valid = s2_v_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_p     = blk_p_q;
    assign out_g     = blk_g_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed and random checks of cla_addsub_pipe (WIDTH=16) against an arithmetic model.
module tb_cla_addsub_pipe;
    localparam int W = 16;
`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout, p, g, ovf, zero;
    } res_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_cout, out_p, out_g, out_ovf, out_zero;
    logic [W-1:0] out_sum;
    res_t         obs, held, r;
    res_t         exp_q[$];
    logic         stalled = 1'b0;
    int           n_cmp = 0, n_err = 0;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_p(out_p), .out_g(out_g), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;
    assign obs = '{sum: out_sum, cout: out_cout, p: out_p, g: out_g, ovf: out_ovf, zero: out_zero};

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        res_t m;
        int   ua, ub, sa, sb, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            u = ua + ub + int'(cin);
            s = sa + sb + int'(cin);
            m.cout = u > 65535;
            m.g    = (ua + ub) > 65535;
            m.p    = (a ^ b) == 16'hFFFF;
        end else begin
            u = ua - ub - int'(cin);
            s = sa - sb - int'(cin);
            m.cout = ua >= ub + int'(cin);
            m.g    = ua > ub;
            m.p    = a == b;
        end
        m.sum  = u[W-1:0];
        m.ovf  = FL & (s > 32767 || s < -32768);
        m.zero = FL & (m.sum == '0);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Scoreboard: record accepted operations, compare delivered ones, and watch stalled outputs.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
        if (rst_n && out_valid) begin
            if (stalled) chk("hold", 32'(obs), 32'(held));
            if (out_ready) begin
                chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("result", 32'(obs), 32'(exp_q.pop_front()));
            end
        end
        stalled = rst_n && out_valid && !out_ready;
        held    = obs;
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
    endtask

    // Issues one op into an empty pipeline and checks it lands exactly two edges later.
    task automatic op_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub, output res_t q);
        drive(a, b, cin, sub);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(out_valid), 32'd1);
        q = obs;
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", 32'(obs), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", 32'(in_ready), 32'd1);

        op_lat(16'hFFFF, 16'h0001, 1'b0, 1'b0, r);
        chk("carry_all", 32'(r), 32'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, FL}));
        op_lat(16'h0005, 16'h0007, 1'b0, 1'b1, r);
        chk("sub_borrow", 32'(r), 32'({16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        op_lat(16'h8000, 16'h0001, 1'b0, 1'b1, r);
        chk("sub_ovf_sum", 32'(r.sum), 32'h7FFF);
        chk("sub_ovf", 32'(r.ovf), 32'(FL));
        op_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, r);
        chk("add_ovf_sum", 32'(r.sum), 32'h8000);
        chk("add_ovf", 32'(r.ovf), 32'(FL));
        op_lat(16'h00FF, 16'hFF00, 1'b1, 1'b0, r);
        chk("blk_prop", 32'({r.sum, r.cout, r.p}), 32'({16'h0000, 1'b1, 1'b1}));

        for (int i = 0; i < 8; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            chk("stream_v", 32'(out_valid), 32'(i >= 1));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_last", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("stream_end", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
        drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("bp_drained", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 2; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_outs", 32'(obs), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        op_lat(16'h1234, 16'h0FED, 1'b1, 1'b1, r);
        chk("midrst_new", 32'(r), 32'(model(16'h1234, 16'h0FED, 1'b1, 1'b1)));

        repeat (4) @(posedge clk);
        #1 chk("final_q", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
